// File: rtl/modulus_lut_chunk_pipe_if.sv
// Bundle for modulus_lut_chunk_pipe: lookup request/response and serial table-load signals.
//   master : drives ce, bypass, in_valid, lut_addr, ld_start, ld_valid, ld_data
//   slave  : drives out_valid, moduli_terms, lookup_drop, ld_ready, tbl_ready
// moduli_terms is packed [NUM_GROUPS-1:0][MODULUS_WIDTH-1:0]; element g is group g's term.
interface modulus_lut_chunk_pipe_if #(
  parameter int MODULUS_WIDTH = 1024,
  parameter int BIT_LEN       = 50,
  parameter int GROUP_BITS    = 5
);
  localparam int NUM_GROUPS = (BIT_LEN + GROUP_BITS - 1) / GROUP_BITS;

  logic                                      ce;
  logic                                      bypass;
  logic                                      in_valid;
  logic [BIT_LEN-1:0]                        lut_addr;
  logic                                      out_valid;
  logic [NUM_GROUPS-1:0][MODULUS_WIDTH-1:0]  moduli_terms;
  logic                                      lookup_drop;
  logic                                      ld_start;
  logic                                      ld_valid;
  logic                                      ld_ready;
  logic [MODULUS_WIDTH-1:0]                  ld_data;
  logic                                      tbl_ready;

  modport master (
    output ce, bypass, in_valid, lut_addr, ld_start, ld_valid, ld_data,
    input  out_valid, moduli_terms, lookup_drop, ld_ready, tbl_ready
  );

  modport slave (
    input  ce, bypass, in_valid, lut_addr, ld_start, ld_valid, ld_data,
    output out_valid, moduli_terms, lookup_drop, ld_ready, tbl_ready
  );
endinterface

// File: rtl/modulus_lut_chunk_pipe.sv
// Runtime-loadable modulus reduction chunk. A BIT_LEN-bit address is cut into
// NUM_GROUPS slices of GROUP_BITS bits; each slice reads its own distributed-RAM
// table of reduction terms. Tables are loaded serially (group-major, index 1..2^GB-1)
// after ld_start; entry 0 of every table reads as zero and is never stored.
// Ports:
//   clk_phase  clock
//   rst_n      asynchronous active-low reset
//   bus        modulus_lut_chunk_pipe_if.slave (lookup + load signals)
// Optional feature: define MODULUS_LUT_OUT_REG_EN to register moduli_terms/out_valid
// (ce-enabled, reset to 0), adding one cycle of latency.
module modulus_lut_chunk_pipe #(
  parameter int MODULUS_WIDTH = 1024,
  parameter int BIT_LEN       = 50,
  parameter int GROUP_BITS    = 5,
  parameter int CUR_LOW_POS   = 2*MODULUS_WIDTH-BIT_LEN
) (
  input logic                     clk_phase,
  input logic                     rst_n,
  modulus_lut_chunk_pipe_if.slave bus
);
  localparam int NUM_GROUPS = (BIT_LEN + GROUP_BITS - 1) / GROUP_BITS;
  localparam int DEPTH      = 1 << GROUP_BITS;
  localparam int PAD_LEN    = NUM_GROUPS * GROUP_BITS;
  localparam int GW         = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;
  // Table contents are derived from this by the loader, not by the hardware.
  localparam int cur_low_pos_unused = CUR_LOW_POS;

  typedef enum logic [1:0] {EMPTY, LOAD, READY} state_t;

  state_t                  state;
  logic [GW-1:0]           grp_cnt;
  logic [GROUP_BITS-1:0]   idx_cnt;
  logic                    ld_ready_q;
  logic                    tbl_ready_q;
  logic                    beat;

  logic [MODULUS_WIDTH-1:0] tbl [NUM_GROUPS][DEPTH];

  logic [BIT_LEN-1:0]      addr_q;
  logic                    vld_q;
  logic                    rdy_q;

  logic [BIT_LEN-1:0]      addr_eff;
  logic                    vld_eff;
  logic                    lookup_ok;
  logic                    hit;
  logic [PAD_LEN-1:0]      addr_pad;
  logic [GROUP_BITS-1:0]   slice;
  logic [NUM_GROUPS-1:0][MODULUS_WIDTH-1:0] terms;

  // A start in the same cycle as a beat wins; the beat is not written.
  assign beat = (state == LOAD) && bus.ld_valid && !bus.ld_start;

  always_ff @(posedge clk_phase or negedge rst_n) begin
    if (!rst_n) begin
      state       <= EMPTY;
      grp_cnt     <= '0;
      idx_cnt     <= GROUP_BITS'(1);
      ld_ready_q  <= 1'b0;
      tbl_ready_q <= 1'b0;
    end else if (bus.ld_start) begin
      state       <= LOAD;
      grp_cnt     <= '0;
      idx_cnt     <= GROUP_BITS'(1);
      ld_ready_q  <= 1'b1;
      tbl_ready_q <= 1'b0;
    end else if (beat) begin
      if (idx_cnt == '1) begin
        idx_cnt <= GROUP_BITS'(1);
        if (grp_cnt == GW'(NUM_GROUPS-1)) begin
          state       <= READY;
          ld_ready_q  <= 1'b0;
          tbl_ready_q <= 1'b1;
        end else begin
          grp_cnt <= grp_cnt + GW'(1);
        end
      end else begin
        idx_cnt <= idx_cnt + GROUP_BITS'(1);
      end
    end
  end

  always_ff @(posedge clk_phase) begin
    if (beat) tbl[grp_cnt][idx_cnt] <= bus.ld_data;
  end

  // rdy_q remembers whether the tables were READY when the request was registered,
  // so a request captured at the edge that completes the load is still dropped.
  always_ff @(posedge clk_phase or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
      vld_q  <= 1'b0;
      rdy_q  <= 1'b0;
    end else if (bus.ce) begin
      addr_q <= bus.lut_addr;
      vld_q  <= bus.in_valid;
      rdy_q  <= (state == READY);
    end
  end

  assign addr_eff  = bus.bypass ? bus.lut_addr : addr_q;
  assign vld_eff   = bus.bypass ? bus.in_valid : vld_q;
  assign lookup_ok = (state == READY) && (bus.bypass || rdy_q);
  assign hit       = vld_eff && lookup_ok;

  always_comb begin
    addr_pad = '0;
    addr_pad[BIT_LEN-1:0] = addr_eff;
    slice = '0;
    terms = '0;
    for (int unsigned g = 0; g < NUM_GROUPS; g++) begin
      slice    = addr_pad[g*GROUP_BITS +: GROUP_BITS];
      terms[g] = (slice == '0) ? '0 : tbl[g][slice];
    end
  end

  assign bus.lookup_drop = vld_eff && !lookup_ok;
  assign bus.ld_ready    = ld_ready_q;
  assign bus.tbl_ready   = tbl_ready_q;

`ifdef MODULUS_LUT_OUT_REG_EN
  logic                                      out_valid_q;
  logic [NUM_GROUPS-1:0][MODULUS_WIDTH-1:0]  terms_q;

  always_ff @(posedge clk_phase or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      terms_q     <= '0;
    end else if (bus.ce) begin
      out_valid_q <= hit;
      terms_q     <= terms;
    end
  end

  assign bus.out_valid    = out_valid_q;
  assign bus.moduli_terms = terms_q;
`else
  assign bus.out_valid    = hit;
  assign bus.moduli_terms = terms;
`endif
endmodule

// File: doc/modulus_lut_chunk_pipe.md
# modulus_lut_chunk_pipe

Parametrised, runtime-loadable successor to the fixed-ROM modulus chunk in the modular-square reduction tree. It splits a `BIT_LEN`-bit chunk of the wide product into `NUM_GROUPS` slices of `GROUP_BITS` bits. Each slice indexes its own table of precomputed reduction terms (`idx·2^(CUR_LOW_POS+g·GROUP_BITS) mod M`, `MODULUS_WIDTH` bits). The block returns one term per group to the compressor-tree adder. Tables are loaded serially after reset, so one bitstream serves any modulus; lookups carry a valid bit through an optional pipeline.

## Interface
- `MODULUS_WIDTH`, 1024: width of each term and of `ld_data`.
- `BIT_LEN`, 50: lookup address width.
- `GROUP_BITS`, 5: slice width. Must satisfy 1 ≤ `GROUP_BITS` ≤ 8.
- `CUR_LOW_POS`, `2*MODULUS_WIDTH-BIT_LEN`: documentation only; the loader computes table contents from it.
- `NUM_GROUPS` (localparam): ceil(`BIT_LEN`/`GROUP_BITS`). The top slice is zero-extended.
- `clk_phase`, in, 1: clock.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `ce`, in, 1: clock enable for the address/valid stage.
- `bypass`, in, 1: 1 = feed `lut_addr`/`in_valid` straight to the tables, skipping the address register.
- `in_valid`, in, 1: a lookup request is present.
- `lut_addr`, in, `BIT_LEN`: lookup address.
- `out_valid`, out, 1: `moduli_terms` holds a valid lookup.
- `moduli_terms`, out, `MODULUS_WIDTH` × `NUM_GROUPS`: term g = table[g][slice g].
- `lookup_drop`, out, 1: one-cycle pulse; a lookup arrived while the tables were not READY.
- `ld_start`, in, 1: pulse that begins or restarts a table load.
- `ld_valid`, in, 1: load data beat present.
- `ld_ready`, out, 1: block accepts a load beat.
- `ld_data`, in, `MODULUS_WIDTH`: table entry.
- `tbl_ready`, out, 1: all tables are loaded.

## Operation
- Entry 0 of every table is hardwired to zero. It is never written and never counted.
- The FSM has three states: EMPTY, LOAD, READY.
  - Reset puts the FSM in EMPTY.
  - `ld_start` moves EMPTY/LOAD/READY → LOAD. It clears `grp_cnt` and sets `idx_cnt` to 1.
  - In LOAD, `ld_ready`=1. A beat transfers when `ld_valid && ld_ready`: it writes `ld_data` to table[`grp_cnt`][`idx_cnt`], then increments `idx_cnt`. After index 2^`GROUP_BITS`-1, `idx_cnt` wraps to 1 and `grp_cnt` increments.
  - The transfer to group `NUM_GROUPS-1`, index 2^`GROUP_BITS`-1 moves the FSM to READY.
- Total load length is `NUM_GROUPS`·(2^`GROUP_BITS`-1) beats.
- `ld_start` and `ld_valid` asserted in the same cycle: the start wins and the beat is not written.
- `ld_valid` outside LOAD is ignored.
- Lookups are accepted only in READY. An `in_valid` outside READY, at the point where it would enter the tables, is discarded and pulses `lookup_drop`. `out_valid` stays 0.
- `ld_start` while in READY:
  - `tbl_ready` drops the next cycle.
  - A lookup already past the address stage completes normally.
  - A lookup still in the address register is dropped.
- Reset mid-load returns the FSM to EMPTY. Table RAM contents are not cleared; `tbl_ready`=0 guards them.
- `ce`=0 holds the address register and its valid bit. An unregistered path is unaffected by `ce`.

## Timing
- Reset values: `out_valid`=0, `lookup_drop`=0, `ld_ready`=0, `tbl_ready`=0, all `moduli_terms`=0. The address register resets to 0, and entry 0 reads as zero.
- `bypass`=0: `lut_addr` is registered on a `clk_phase` edge with `ce`=1. Terms and `out_valid` appear combinationally after that edge (latency 1).
- `bypass`=1: terms and `out_valid` follow `lut_addr`/`in_valid` combinationally (latency 0).
- `tbl_ready` rises the cycle after the last beat. A lookup registered at that same edge is still dropped.
- Table reads are asynchronous (distributed RAM). A write is visible to reads from the next cycle.

## Configuration
- `MODULUS_LUT_OUT_REG_EN`
  - Defined: an output register sits on `moduli_terms` and `out_valid`. It is enabled by `ce` and reset to 0. Latency becomes 2 (`bypass`=0) or 1 (`bypass`=1).
  - Undefined: outputs are combinational from the table read.

## Test plan
Bench parameters: `MODULUS_WIDTH`=16, `BIT_LEN`=8, `GROUP_BITS`=4 → 2 groups, 30 load beats.
- **Reset then lookup:** `in_valid`=1, `lut_addr`=8'h21 before any load → `lookup_drop` pulses, `out_valid`=0, `tbl_ready`=0.
- **Full load:** 30 beats with data = 16'h0100·g + idx, `ld_valid` toggled randomly → `tbl_ready`=1 one cycle after beat 30, `ld_ready`=0. Then lookup 8'h3A (`bypass`=0) → one cycle later `moduli_terms`={16'h0103, 16'h000A}, `out_valid`=1.
- **Bypass and zero entry:** `bypass`=1, `lut_addr`=8'h50 → same cycle terms {16'h0105, 16'h0000}.
- **`ce` stall:** `ce`=0 for 3 cycles while `lut_addr` changes → outputs hold the last registered lookup.
- **Restart:** `ld_start` with `ld_valid` high at beat 12, then 30 new beats → first beat is discarded, new data is used, `tbl_ready` low throughout.
- **Reset mid-load:** assert `rst_n`=0 at beat 20 → `ld_ready`=0, `tbl_ready`=0. A fresh full load then passes the second scenario's checks.
